// File: rtl/sk_pkg.sv
// Shared widths, register map and CTRL bit positions for the performance-analyzer register block.
package sk_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int SCR_N  = 256;
  localparam int SCR_AW = 8;

  localparam logic [ADDR_W-1:0] A_CTRL  = 9'h100;
  localparam logic [ADDR_W-1:0] A_CYCLE = 9'h101;
  localparam logic [ADDR_W-1:0] A_WRCNT = 9'h102;
  localparam logic [ADDR_W-1:0] A_RDCNT = 9'h103;
  localparam logic [ADDR_W-1:0] A_ID    = 9'h104;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_CLR_BIT = 1;

  localparam logic [DATA_W-1:0] ID_VAL = 32'h534B_0001;
endpackage

// File: rtl/sk_perf_counters.sv
// CTRL register (count enable, self-clearing clear) and the cycle/write/read strobe counters.
module sk_perf_counters
  import sk_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_wr,
  input  logic [DATA_W-1:0] ctrl_wdata,
  input  logic              wr_stb,
  input  logic              rd_stb,
  output logic              cnt_en,
  output logic [DATA_W-1:0] cycle_cnt,
  output logic [DATA_W-1:0] wr_cnt,
  output logic [DATA_W-1:0] rd_cnt
);
  logic              cnt_en_q, cnt_en_d;
  logic [DATA_W-1:0] cycle_q, cycle_d, wr_q, wr_d, rd_q, rd_d;
  logic              clr;

  assign clr = ctrl_wr && ctrl_wdata[CTRL_CLR_BIT];

  // The enable in effect this cycle is the old one; a CTRL write only gates later cycles.
  always_comb begin
    cnt_en_d = ctrl_wr ? ctrl_wdata[CTRL_EN_BIT] : cnt_en_q;
    cycle_d  = cycle_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    if (clr) begin
      cycle_d = '0;
      wr_d    = '0;
      rd_d    = '0;
    end else if (cnt_en_q) begin
      cycle_d = cycle_q + 1'b1;
      if (wr_stb) wr_d = wr_q + 1'b1;
      if (rd_stb) rd_d = rd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_en_q <= 1'b1;
      cycle_q  <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
    end else begin
      cnt_en_q <= cnt_en_d;
      cycle_q  <= cycle_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
    end
  end

  assign cnt_en    = cnt_en_q;
  assign cycle_cnt = cycle_q;
  assign wr_cnt    = wr_q;
  assign rd_cnt    = rd_q;
endmodule

// File: rtl/sk_module.sv
// Register block top: 256-word scratch store, perf counter bank and registered read mux.
module sk_module
  import sk_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_address,
  input  logic              read,
  input  logic [DATA_W-1:0] write_data,
  input  logic              write,
  output logic [DATA_W-1:0] read_data
);
  logic [DATA_W-1:0] scr_q [SCR_N];
  logic [DATA_W-1:0] scr_d [SCR_N];
  logic [DATA_W-1:0] read_data_q, read_data_d, rd_val;
  logic [DATA_W-1:0] cycle_cnt, wr_cnt, rd_cnt;
  logic              cnt_en;
  logic              in_scr;

  assign in_scr = !read_address[ADDR_W-1];

  sk_perf_counters u_cnt (
    .clk        (clk),
    .rst        (reset),
    .ctrl_wr    (write && (read_address == A_CTRL)),
    .ctrl_wdata (write_data),
    .wr_stb     (write),
    .rd_stb     (read),
    .cnt_en     (cnt_en),
    .cycle_cnt  (cycle_cnt),
    .wr_cnt     (wr_cnt),
    .rd_cnt     (rd_cnt)
  );

  always_comb begin
    scr_d = scr_q;
    if (write && in_scr) scr_d[read_address[SCR_AW-1:0]] = write_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SCR_N; i++) scr_q[i] <= '0;
    end else begin
      scr_q <= scr_d;
    end
  end

  // Sourced from pre-edge state, so a same-address read+write returns the old word.
  always_comb begin
    rd_val = '0;
    if (in_scr) begin
      rd_val = scr_q[read_address[SCR_AW-1:0]];
    end else begin
      case (read_address)
        A_CTRL:  rd_val = {{(DATA_W-1){1'b0}}, cnt_en};
        A_CYCLE: rd_val = cycle_cnt;
        A_WRCNT: rd_val = wr_cnt;
        A_RDCNT: rd_val = rd_cnt;
        A_ID:    rd_val = ID_VAL;
        default: rd_val = '0;
      endcase
    end
    read_data_d = read ? rd_val : read_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) read_data_q <= '0;
    else       read_data_q <= read_data_d;
  end

  assign read_data = read_data_q;
endmodule

// File: tb/tb_sk_module.sv
// Directed bench for sk_module: vector table for map/storage, hand sequences for counters and reset.
module tb_sk_module;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [8:0]  read_address = '0;
  logic        read = 1'b0;
  logic [31:0] write_data = '0;
  logic        write = 1'b0;
  logic [31:0] read_data;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic        chk;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[$];

  sk_module dut (
    .clk          (clk),
    .reset        (reset),
    .read_address (read_address),
    .read         (read),
    .write_data   (write_data),
    .write        (write),
    .read_data    (read_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One bus cycle: drive at negedge, sample 1ns after the rising edge.
  task automatic cyc(input logic r, input logic w, input logic [8:0] a, input logic [31:0] d);
    @(negedge clk);
    read = r; write = w; read_address = a; write_data = d;
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic rd_chk(input logic [8:0] a, input logic [31:0] exp, input string name);
    cyc(1'b1, 1'b0, a, '0);
    check(name, read_data, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, '0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_read_data", read_data, 32'h0);
    reset = 1'b0;
  endtask

  function automatic void add(input logic r, input logic w, input logic [8:0] a,
                              input logic [31:0] d, input logic c, input logic [31:0] e,
                              input string n);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.chk = c; v.exp = e; v.name = n;
    tbl.push_back(v);
  endfunction

  initial begin
    add(0, 0, 9'h100, 32'h0,        0, 32'h0,        "idle");
    add(1, 0, 9'h100, 32'h0,        1, 32'h1,        "ctrl_reset");
    add(0, 1, 9'h000, 32'hAAAAAAAA, 0, 32'h0,        "wr0");
    add(1, 0, 9'h000, 32'h0,        1, 32'hAAAAAAAA, "rd0");
    add(0, 1, 9'h002, 32'hBBBBBBBB, 0, 32'h0,        "wr2");
    add(0, 1, 9'h004, 32'hCCCCCCCC, 0, 32'h0,        "wr4");
    add(1, 0, 9'h002, 32'h0,        1, 32'hBBBBBBBB, "rd2");
    add(1, 0, 9'h004, 32'h0,        1, 32'hCCCCCCCC, "rd4");
    add(1, 0, 9'h000, 32'h0,        1, 32'hAAAAAAAA, "rd0_again");
    add(0, 0, 9'h104, 32'h0,        1, 32'hAAAAAAAA, "hold");
    add(1, 0, 9'h104, 32'h0,        1, 32'h534B0001, "id");
    add(1, 0, 9'h050, 32'h0,        1, 32'h0,        "scr_reset");
    add(1, 0, 9'h1FF, 32'h0,        1, 32'h0,        "rsvd_1ff");
    add(0, 1, 9'h1FF, 32'h12345678, 0, 32'h0,        "wr_1ff");
    add(1, 0, 9'h1FF, 32'h0,        1, 32'h0,        "rsvd_1ff_wi");
    add(1, 0, 9'h105, 32'h0,        1, 32'h0,        "rsvd_105");
    add(0, 1, 9'h104, 32'hFFFFFFFF, 0, 32'h0,        "wr_id");
    add(1, 0, 9'h104, 32'h0,        1, 32'h534B0001, "id_ro");
    add(1, 1, 9'h002, 32'hDDDDDDDD, 1, 32'hBBBBBBBB, "rw_same_old");
    add(1, 0, 9'h002, 32'h0,        1, 32'hDDDDDDDD, "rw_same_new");
    add(0, 1, 9'h0FF, 32'h0F0F0F0F, 0, 32'h0,        "wr_ff");
    add(1, 0, 9'h0FF, 32'h0,        1, 32'h0F0F0F0F, "rd_ff");

    do_reset();
    foreach (tbl[i]) begin
      cyc(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].chk) check(tbl[i].name, read_data, tbl[i].exp);
    end

    // Counters: one idle edge follows reset release, then 10 idle, 3 writes, 2 reads.
    do_reset();
    idle(10);
    cyc(0, 1, 9'h010, 32'h1);
    cyc(0, 1, 9'h011, 32'h2);
    cyc(0, 1, 9'h012, 32'h3);
    rd_chk(9'h010, 32'h1, "cnt_rd_a");
    rd_chk(9'h011, 32'h2, "cnt_rd_b");
    rd_chk(9'h103, 32'd2, "rd_cnt");
    rd_chk(9'h102, 32'd3, "wr_cnt");
    rd_chk(9'h101, 32'd18, "cycle_cnt");

    // Clear with enable off: counters zero and stay frozen.
    cyc(0, 1, 9'h100, 32'h2);
    rd_chk(9'h101, 32'h0, "clr_cycle");
    rd_chk(9'h102, 32'h0, "clr_wr");
    rd_chk(9'h103, 32'h0, "clr_rd");
    rd_chk(9'h100, 32'h0, "ctrl_en_off");
    idle(5);
    rd_chk(9'h101, 32'h0, "frozen_cycle");

    // Re-enable: the enabling write cycle itself is not counted.
    cyc(0, 1, 9'h100, 32'h1);
    rd_chk(9'h101, 32'h0, "reen_cycle0");
    rd_chk(9'h101, 32'h1, "reen_cycle1");
    rd_chk(9'h103, 32'd2, "reen_rd");
    rd_chk(9'h102, 32'h0, "reen_wr");

    // Reset asserted in the middle of a read with scratch loaded.
    cyc(0, 1, 9'h020, 32'h55AA55AA);
    rd_chk(9'h020, 32'h55AA55AA, "pre_reset_rd");
    @(negedge clk);
    read = 1'b1; read_address = 9'h020;
    #2 reset = 1'b1;
    #1 check("reset_async", read_data, 32'h0);
    @(posedge clk);
    #1 check("reset_held", read_data, 32'h0);
    @(negedge clk);
    reset = 1'b0; read = 1'b0;
    rd_chk(9'h020, 32'h0, "scr_after_reset");
    rd_chk(9'h100, 32'h1, "ctrl_after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
